// File: rtl/ps2_key_tracker_pkg.sv
// ============================================================================
// Module : ps2_key_tracker_pkg
// Brief  : Shared PS/2 codes, FSM state types and the game-key lookup.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_key_tracker_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_UP    = 8'h75;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {PFX_NONE, PFX_E0, PFX_F0, PFX_E0F0} pfx_state_e;
    typedef enum logic [2:0] {K_A, K_D, K_W, K_SPACE, K_R, K_LEFT, K_RIGHT, K_UP} key_e;

    typedef struct packed {
        logic hit;
        key_e key;
    } key_map_t;

    // Extended and base code spaces overlap, so the prefix decides the table.
    function automatic key_map_t map_key(input logic [7:0] code, input logic ext);
        key_map_t m;
        m.hit = 1'b1;
        m.key = K_A;
        if (ext) begin
            case (code)
                KEY_LEFT:  m.key = K_LEFT;
                KEY_RIGHT: m.key = K_RIGHT;
                KEY_UP:    m.key = K_UP;
                default:   m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                KEY_A:     m.key = K_A;
                KEY_D:     m.key = K_D;
                KEY_W:     m.key = K_W;
                KEY_SPACE: m.key = K_SPACE;
                KEY_R:     m.key = K_R;
                default:   m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_tracker_if.sv
// ============================================================================
// Module : ps2_key_tracker_if
// Brief  : PS/2 pin inputs and decoded game-key outputs of the tracker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ps2_key_tracker_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       left;
    logic       right;
    logic       jump;
    logic       retry;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  left, right, jump, retry, scan_code, code_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output left, right, jump, retry, scan_code, code_valid, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// Module : ps2_rx
// Brief  : PS/2 frame receiver: synchroniser, falling-edge detect, 11-bit FSM, watchdog.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_rx
    import ps2_key_tracker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);
    localparam int             CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic                   clk_s, data_s, fall, any_edge, timeout;
    rx_state_e              state, state_next;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_bit;
    logic [CNT_W-1:0]       wd_cnt;
    logic                   accept, err;

    // Idle PS/2 lines float high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign fall     = clk_prev & ~clk_s;
    assign any_edge = clk_prev ^ clk_s;
    assign timeout  = (state != RX_IDLE) && (wd_cnt == TIMEOUT_VAL);

    always_ff @(posedge clk) begin
        if (!rstn) state <= RX_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = RX_IDLE;
        end else if (fall) begin
            case (state)
                RX_IDLE:   if (!data_s) state_next = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_next = RX_PARITY;
                RX_PARITY: state_next = RX_STOP;
                RX_STOP:   state_next = RX_IDLE;
                default:   state_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        accept = 1'b0;
        err    = 1'b0;
        if (timeout) begin
            err = 1'b1;
        end else if (fall) begin
            case (state)
                RX_IDLE: err = data_s;
                RX_STOP: begin
                    if (data_s && (^{shreg, par_bit})) accept = 1'b1;
                    else                               err    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            wd_cnt     <= '0;
            scan_code  <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= accept;
            frame_err  <= err;
            if (accept) scan_code <= shreg;
            if (state == RX_IDLE || any_edge) wd_cnt <= '0;
            else if (!timeout)                wd_cnt <= wd_cnt + 1'b1;
            if (fall) begin
                case (state)
                    RX_IDLE:   bit_cnt <= 3'd0;
                    RX_DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: par_bit <= data_s;
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_key_tracker.sv
// ============================================================================
// Module : ps2_key_tracker
// Brief  : PS/2 receiver, E0/F0 prefix FSM and held-flag register for game keys.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic               clk,
    input  logic               rstn,
    ps2_key_tracker_if.slave   bus
);
    logic [7:0] scan_code;
    logic       code_valid, frame_err;
    pfx_state_e pfx_state, pfx_next;
    logic       make_evt, brk_evt, ext_evt;
    key_map_t   km;
    logic [7:0] held;
    logic       retry;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .rstn       (rstn),
        .ps2_clk    (bus.ps2_clk),
        .ps2_data   (bus.ps2_data),
        .scan_code  (scan_code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (!rstn) pfx_state <= PFX_NONE;
        else       pfx_state <= pfx_next;
    end

    always_comb begin
        pfx_next = pfx_state;
        if (code_valid) begin
            case (pfx_state)
                PFX_NONE: begin
                    if      (scan_code == PS2_EXT) pfx_next = PFX_E0;
                    else if (scan_code == PS2_BRK) pfx_next = PFX_F0;
                    else                           pfx_next = PFX_NONE;
                end
                PFX_E0: begin
                    if      (scan_code == PS2_BRK) pfx_next = PFX_E0F0;
                    else if (scan_code == PS2_EXT) pfx_next = PFX_E0;
                    else                           pfx_next = PFX_NONE;
                end
                default: pfx_next = PFX_NONE;
            endcase
        end
    end

    always_comb begin
        make_evt = 1'b0;
        brk_evt  = 1'b0;
        ext_evt  = 1'b0;
        if (code_valid) begin
            case (pfx_state)
                PFX_NONE: make_evt = (scan_code != PS2_EXT) && (scan_code != PS2_BRK);
                PFX_E0: begin
                    make_evt = (scan_code != PS2_EXT) && (scan_code != PS2_BRK);
                    ext_evt  = 1'b1;
                end
                PFX_F0:  brk_evt = 1'b1;
                default: begin
                    brk_evt = 1'b1;
                    ext_evt = 1'b1;
                end
            endcase
        end
    end

    assign km = map_key(scan_code, ext_evt);

    // retry fires only on the not-held -> held transition, so typematic repeats are silent.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            held  <= 8'h00;
            retry <= 1'b0;
        end else begin
            retry <= 1'b0;
            if (km.hit && make_evt) begin
                held[km.key] <= 1'b1;
                if (km.key == K_R && !held[K_R]) retry <= 1'b1;
            end else if (km.hit && brk_evt) begin
                held[km.key] <= 1'b0;
            end
        end
    end

    assign bus.left       = held[K_LEFT]  | held[K_A];
    assign bus.right      = held[K_RIGHT] | held[K_D];
    assign bus.jump       = held[K_UP]    | held[K_W] | held[K_SPACE];
    assign bus.retry      = retry;
    assign bus.scan_code  = scan_code;
    assign bus.code_valid = code_valid;
    assign bus.frame_err  = frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
// ============================================================================
// Module : tb_ps2_key_tracker
// Brief  : Scoreboard bench for ps2_key_tracker driving PS/2 frames on the pins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_tracker;
    import ps2_key_tracker_pkg::*;

    localparam int HALF = 8;
    localparam int GAP  = 20;
    localparam int TMO  = 20000;

    typedef struct {
        bit         err;
        logic [7:0] code;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ps2_key_tracker_if bus();

    ps2_key_tracker #(
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    exp_t sb[$];
    int   checks = 0, fails = 0;
    int   valid_cnt = 0, err_cnt = 0, retry_cnt = 0;
    bit   retry_prev = 1'b0, retry_wide = 1'b0;

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            repeat (HALF) @(posedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            bus.ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = bad_par ? (^b) : ~(^b);
        if (bad_par || bad_stop) sb.push_back('{err: 1'b1, code: 8'h00});
        else                     sb.push_back('{err: 1'b0, code: b});
        send_bits({~bad_stop, par, b, 1'b0}, 11);
        bus.ps2_data = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic test_reset();
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rstn = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.left, bus.right, bus.jump, bus.retry, bus.code_valid, bus.frame_err} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {bus.left, bus.right, bus.jump, bus.retry, bus.code_valid, bus.frame_err});
        end
        checks++;
        if (bus.scan_code !== 8'h00) begin
            fails++;
            $display("FAIL reset_scan_code: got %02h, expected 00", bus.scan_code);
        end
        rstn = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic test_ext_left();
        bit seen;
        send_frame(PS2_EXT, 1'b0, 1'b0);
        fork
            send_frame(KEY_LEFT, 1'b0, 1'b0);
            begin
                seen = 1'b0;
                for (int i = 0; i < 400 && !seen; i++) begin
                    @(negedge clk);
                    if (bus.code_valid) seen = 1'b1;
                end
                checks++;
                if (!seen) begin
                    fails++;
                    $display("FAIL ext_left_valid: code_valid never seen, expected a pulse");
                end else begin
                    checks++;
                    if (bus.left !== 1'b0) begin
                        fails++;
                        $display("FAIL ext_left_early: left=%b one clk after stop, expected 0", bus.left);
                    end
                    @(negedge clk);
                    checks++;
                    if ({bus.left, bus.right, bus.jump} !== 3'b100) begin
                        fails++;
                        $display("FAIL ext_left_set: lrj=%b two clks after stop, expected 100",
                                 {bus.left, bus.right, bus.jump});
                    end
                end
            end
        join
        send_frame(PS2_EXT, 1'b0, 1'b0);
        send_frame(PS2_BRK, 1'b0, 1'b0);
        send_frame(KEY_LEFT, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({bus.left, bus.right, bus.jump} !== 3'b000) begin
            fails++;
            $display("FAIL ext_left_release: lrj=%b, expected 000", {bus.left, bus.right, bus.jump});
        end
    endtask

    task automatic test_retry_typematic();
        int v0, r0;
        v0 = valid_cnt;
        r0 = retry_cnt;
        send_frame(KEY_R, 1'b0, 1'b0);
        checks++;
        if (retry_cnt - r0 !== 1) begin
            fails++;
            $display("FAIL retry_first: %0d pulses after first R make, expected 1", retry_cnt - r0);
        end
        send_frame(KEY_R, 1'b0, 1'b0);
        send_frame(KEY_R, 1'b0, 1'b0);
        send_frame(PS2_BRK, 1'b0, 1'b0);
        send_frame(KEY_R, 1'b0, 1'b0);
        checks++;
        if (retry_cnt - r0 !== 1) begin
            fails++;
            $display("FAIL retry_total: %0d pulses, expected 1", retry_cnt - r0);
        end
        checks++;
        if (retry_wide !== 1'b0) begin
            fails++;
            $display("FAIL retry_width: pulse wider than 1 clk, expected 1 clk");
        end
        checks++;
        if (valid_cnt - v0 !== 5) begin
            fails++;
            $display("FAIL retry_valid_count: %0d code_valid pulses, expected 5", valid_cnt - v0);
        end
        checks++;
        if (bus.scan_code !== KEY_R) begin
            fails++;
            $display("FAIL retry_scan_code: got %02h, expected 2d", bus.scan_code);
        end
    endtask

    task automatic test_frame_errors();
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(KEY_A, 1'b1, 1'b0);
        checks++;
        if (err_cnt - e0 !== 1 || valid_cnt !== v0) begin
            fails++;
            $display("FAIL parity_err: err pulses=%0d valid pulses=%0d, expected 1 and 0",
                     err_cnt - e0, valid_cnt - v0);
        end
        checks++;
        if (bus.left !== 1'b0) begin
            fails++;
            $display("FAIL parity_left: left=%b, expected 0", bus.left);
        end
        send_frame(KEY_A, 1'b0, 1'b0);
        checks++;
        if (bus.left !== 1'b1) begin
            fails++;
            $display("FAIL parity_recover: left=%b, expected 1", bus.left);
        end
        e0 = err_cnt;
        send_frame(KEY_D, 1'b0, 1'b1);
        checks++;
        if (err_cnt - e0 !== 1 || bus.right !== 1'b0) begin
            fails++;
            $display("FAIL stop_err: err pulses=%0d right=%b, expected 1 and 0", err_cnt - e0, bus.right);
        end
        send_frame(PS2_BRK, 1'b0, 1'b0);
        send_frame(KEY_A, 1'b0, 1'b0);
        checks++;
        if ({bus.left, bus.right, bus.jump} !== 3'b000) begin
            fails++;
            $display("FAIL a_release: lrj=%b, expected 000", {bus.left, bus.right, bus.jump});
        end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        sb.push_back('{err: 1'b1, code: 8'h00});
        send_bits({3'b111, KEY_SPACE, 1'b0}, 4);
        bus.ps2_data = 1'b1;
        repeat (TMO + 100) @(posedge clk);
        checks++;
        if (err_cnt - e0 !== 1) begin
            fails++;
            $display("FAIL timeout_err: %0d frame_err pulses, expected 1", err_cnt - e0);
        end
        send_frame(KEY_SPACE, 1'b0, 1'b0);
        checks++;
        if ({bus.left, bus.right, bus.jump} !== 3'b001) begin
            fails++;
            $display("FAIL timeout_recover: lrj=%b, expected 001", {bus.left, bus.right, bus.jump});
        end
    endtask

    task automatic test_both_and_reset();
        send_frame(KEY_A, 1'b0, 1'b0);
        send_frame(KEY_D, 1'b0, 1'b0);
        checks++;
        if ({bus.left, bus.right, bus.jump} !== 3'b111) begin
            fails++;
            $display("FAIL both_held: lrj=%b, expected 111", {bus.left, bus.right, bus.jump});
        end
        send_bits({3'b111, KEY_W, 1'b0}, 5);
        @(posedge clk);
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.left, bus.right, bus.jump, bus.retry, bus.code_valid, bus.frame_err, bus.scan_code}
                !== 14'b0) begin
            fails++;
            $display("FAIL midframe_reset: outputs=%b scan=%02h, expected all 0",
                     {bus.left, bus.right, bus.jump, bus.retry, bus.code_valid, bus.frame_err},
                     bus.scan_code);
        end
        @(posedge clk);
        rstn = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (50) @(posedge clk);
        send_frame(KEY_D, 1'b0, 1'b0);
        checks++;
        if ({bus.left, bus.right, bus.jump} !== 3'b010 || bus.scan_code !== KEY_D) begin
            fails++;
            $display("FAIL post_reset_frame: lrj=%b scan=%02h, expected 010 and 23",
                     {bus.left, bus.right, bus.jump}, bus.scan_code);
        end
        send_frame(PS2_BRK, 1'b0, 1'b0);
        send_frame(KEY_D, 1'b0, 1'b0);
    endtask

    task automatic test_orphan_break();
        send_frame(PS2_BRK, 1'b0, 1'b0);
        send_frame(KEY_UP, 1'b0, 1'b0);
        checks++;
        if ({bus.left, bus.right, bus.jump} !== 3'b000) begin
            fails++;
            $display("FAIL orphan_break: lrj=%b, expected 000", {bus.left, bus.right, bus.jump});
        end
        send_frame(KEY_UP, 1'b0, 1'b0);
        checks++;
        if ({bus.left, bus.right, bus.jump} !== 3'b000) begin
            fails++;
            $display("FAIL base_75_unmapped: lrj=%b, expected 000", {bus.left, bus.right, bus.jump});
        end
        send_frame(PS2_EXT, 1'b0, 1'b0);
        send_frame(KEY_UP, 1'b0, 1'b0);
        checks++;
        if ({bus.left, bus.right, bus.jump} !== 3'b001) begin
            fails++;
            $display("FAIL ext_up_make: lrj=%b, expected 001", {bus.left, bus.right, bus.jump});
        end
        send_frame(PS2_EXT, 1'b0, 1'b0);
        send_frame(PS2_BRK, 1'b0, 1'b0);
        send_frame(KEY_UP, 1'b0, 1'b0);
        checks++;
        if ({bus.left, bus.right, bus.jump} !== 3'b000) begin
            fails++;
            $display("FAIL ext_up_break: lrj=%b, expected 000", {bus.left, bus.right, bus.jump});
        end
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rstn) begin
                    if (bus.retry) begin
                        retry_cnt++;
                        if (retry_prev) retry_wide = 1'b1;
                    end
                    retry_prev = bus.retry;
                    if (bus.code_valid) valid_cnt++;
                    if (bus.frame_err)  err_cnt++;
                    if (bus.code_valid || bus.frame_err) begin
                        checks++;
                        if (sb.size() == 0) begin
                            fails++;
                            $display("FAIL sb_unexpected: valid=%b err=%b scan=%02h, expected no event",
                                     bus.code_valid, bus.frame_err, bus.scan_code);
                        end else begin
                            e = sb.pop_front();
                            if (bus.frame_err !== e.err || bus.code_valid !== !e.err ||
                                (!e.err && bus.scan_code !== e.code)) begin
                                fails++;
                                $display("FAIL sb_event: valid=%b err=%b scan=%02h, expected err=%b scan=%02h",
                                         bus.code_valid, bus.frame_err, bus.scan_code, e.err, e.code);
                            end
                        end
                    end
                end else begin
                    retry_prev = 1'b0;
                end
            end
        join_none

        test_reset();
        test_ext_left();
        test_retry_typematic();
        test_frame_errors();
        test_timeout();
        test_both_and_reset();
        test_orphan_break();

        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d expected events never seen, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
